// File: rtl/thor2024_alu_sequencer_if.sv
// Issue, ALU-operand and writeback signals of the Thor2024 ALU sequencer.
// Both in_* and out_* are valid/ready: a transfer happens on a rising edge where valid
// and ready are both high, and the sender holds its payload stable while valid waits on ready.
interface thor2024_alu_sequencer_if #(
    parameter int TAGW = 5,
    parameter int IRW  = 41
);
    logic            in_valid;
    logic            in_ready;
    logic [IRW-1:0]  in_ir;
    logic [63:0]     in_a;
    logic [63:0]     in_b;
    logic [63:0]     in_c;
    logic [63:0]     in_t;
    logic [63:0]     in_p;
    logic            in_div;
    logic [TAGW-1:0] in_tag;

    logic [IRW-1:0]  alu_ir;
    logic [63:0]     alu_a;
    logic [63:0]     alu_b;
    logic [63:0]     alu_c;
    logic [63:0]     alu_t;
    logic [63:0]     alu_p;
    logic            alu_div;
    logic [63:0]     alu_o;
    logic            alu_mul_done;
    logic            alu_div_done;
    logic            alu_div_dbz;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_res;
    logic [TAGW-1:0] out_tag;
    logic            out_exc;

    modport slave (
        input  in_valid, in_ir, in_a, in_b, in_c, in_t, in_p, in_div, in_tag,
        input  alu_o, alu_mul_done, alu_div_done, alu_div_dbz,
        input  out_ready,
        output in_ready,
        output alu_ir, alu_a, alu_b, alu_c, alu_t, alu_p, alu_div,
        output out_valid, out_res, out_tag, out_exc
    );

    modport master (
        output in_valid, in_ir, in_a, in_b, in_c, in_t, in_p, in_div, in_tag,
        output alu_o, alu_mul_done, alu_div_done, alu_div_dbz,
        output out_ready,
        input  in_ready,
        input  alu_ir, alu_a, alu_b, alu_c, alu_t, alu_p, alu_div,
        input  out_valid, out_res, out_tag, out_exc
    );
endinterface

// File: rtl/thor2024_alu_sequencer.sv
// Holds one issued op on the ALU inputs for its class latency, then captures the
// result and tag into a register offered to writeback; one op in flight at a time.
module thor2024_alu_sequencer #(
    parameter int TAGW    = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_MIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    thor2024_alu_sequencer_if.slave    bus,
    output logic [2:0]                 dbg_state
);
    localparam int MAXL = (MUL_LAT > DIV_MIN) ? MUL_LAT : DIV_MIN;
    localparam int CW   = $clog2(MAXL) + 1;

    localparam logic [6:0] OP_R2    = 7'd2;
    localparam logic [6:0] OP_MULI  = 7'd6;
    localparam logic [6:0] OP_MULUI = 7'd14;
    localparam logic [6:0] OP_DIVI  = 7'd16;
    localparam logic [6:0] OP_DIVUI = 7'd17;
    localparam logic [6:0] FN_MUL   = 7'd16;
    localparam logic [6:0] FN_MULU  = 7'd17;
    localparam logic [6:0] FN_MULH  = 7'd18;
    localparam logic [6:0] FN_MULUH = 7'd19;
    localparam logic [6:0] FN_DIV   = 7'd20;
    localparam logic [6:0] FN_MOD   = 7'd21;
    localparam logic [6:0] FN_DIVU  = 7'd22;
    localparam logic [6:0] FN_MODU  = 7'd23;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        MWAIT = 3'd2,
        DWAIT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_d, cls_state;
    logic [CW-1:0] cnt, cnt_d;
    logic          in_rdy, accept, capture, exc_d;
    logic          is_mul, is_div;
    logic [6:0]    opc, fn;

    assign opc = bus.in_ir[6:0];
    assign fn  = bus.in_ir[40:34];

    // Predicate bit 0 clear means the ALU just passes t through, so no wait is needed.
    always_comb begin
        is_mul = ((opc == OP_R2) && (fn == FN_MUL || fn == FN_MULU || fn == FN_MULH || fn == FN_MULUH))
               || opc == OP_MULI || opc == OP_MULUI;
        is_div = ((opc == OP_R2) && (fn == FN_DIV || fn == FN_MOD || fn == FN_DIVU || fn == FN_MODU))
               || opc == OP_DIVI || opc == OP_DIVUI;
        cls_state = EXEC;
        if (bus.in_p[0]) begin
            if (is_mul)      cls_state = MWAIT;
            else if (is_div) cls_state = DWAIT;
        end
    end

    always_comb begin
        in_rdy  = ((state == IDLE) || (state == DONE && bus.out_ready)) && !flush;
        accept  = bus.in_valid && in_rdy;
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        exc_d   = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_d = cls_state;
                        cnt_d   = '0;
                    end
                end
                EXEC: begin
                    capture = 1'b1;
                    state_d = DONE;
                end
                MWAIT: begin
                    if (cnt >= CW'(MUL_LAT - 1) && bus.alu_mul_done) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else if (cnt != '1) begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                DWAIT: begin
                    if (cnt >= CW'(DIV_MIN - 1) && bus.alu_div_done) begin
                        capture = 1'b1;
                        exc_d   = bus.alu_div_dbz;
                        state_d = DONE;
                    end else if (cnt != '1) begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            state_d = cls_state;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Operands stay on the ALU until the next accept; a flush deliberately leaves them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.alu_ir  <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            bus.alu_c   <= '0;
            bus.alu_t   <= '0;
            bus.alu_p   <= '0;
            bus.alu_div <= 1'b0;
            bus.out_res <= '0;
            bus.out_tag <= '0;
            bus.out_exc <= 1'b0;
        end else begin
            if (accept) begin
                bus.alu_ir  <= bus.in_ir;
                bus.alu_a   <= bus.in_a;
                bus.alu_b   <= bus.in_b;
                bus.alu_c   <= bus.in_c;
                bus.alu_t   <= bus.in_t;
                bus.alu_p   <= bus.in_p;
                bus.alu_div <= bus.in_div;
                bus.out_tag <= bus.in_tag;
            end
            if (capture) begin
                bus.out_res <= bus.alu_o;
                bus.out_exc <= exc_d;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == DONE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_thor2024_alu_sequencer.sv
// Directed bench for thor2024_alu_sequencer: vector table plus hand sequences for
// stalled writeback, flush during divide and reset during multiply.
module tb_thor2024_alu_sequencer;
    localparam logic [6:0] OP_R2    = 7'd2;
    localparam logic [6:0] OP_MULI  = 7'd6;
    localparam logic [6:0] OP_MULUI = 7'd14;
    localparam logic [6:0] OP_DIVI  = 7'd16;
    localparam logic [6:0] FN_ADD   = 7'd4;
    localparam logic [6:0] FN_DIV   = 7'd20;
    localparam logic [6:0] FN_MODU  = 7'd23;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] dbg_state;
    logic       mul_done_en = 1'b1;
    logic       div_done_en = 1'b1;
    int         n_cmp = 0;
    int         n_fail = 0;

    thor2024_alu_sequencer_if #(.TAGW(5)) bus ();

    thor2024_alu_sequencer #(.TAGW(5), .MUL_LAT(4), .DIV_MIN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: combinational from the held operands, done flags under bench control.
    logic [6:0] m_op, m_fn;
    always_comb begin
        m_op = bus.alu_ir[6:0];
        m_fn = bus.alu_ir[40:34];
        bus.alu_o       = 64'd0;
        bus.alu_div_dbz = 1'b0;
        if (!bus.alu_p[0]) begin
            bus.alu_o = bus.alu_t;
        end else begin
            case (m_op)
                OP_R2: begin
                    if (m_fn == FN_ADD) bus.alu_o = bus.alu_a + bus.alu_b;
                    else if (m_fn == FN_DIV && bus.alu_b != 0) bus.alu_o = $signed(bus.alu_a) / $signed(bus.alu_b);
                    else if (m_fn == FN_MODU && bus.alu_b != 0) bus.alu_o = bus.alu_a % bus.alu_b;
                end
                OP_MULI, OP_MULUI: bus.alu_o = bus.alu_a * bus.alu_b;
                OP_DIVI: begin
                    if (bus.alu_b == 0) bus.alu_div_dbz = 1'b1;
                    else if (bus.alu_div) bus.alu_o = $signed(bus.alu_a) / $signed(bus.alu_b);
                    else bus.alu_o = bus.alu_a / bus.alu_b;
                end
                default: bus.alu_o = 64'd0;
            endcase
        end
        bus.alu_mul_done = mul_done_en;
        bus.alu_div_done = div_done_en;
    end

    typedef struct {
        logic [40:0] ir;
        logic [63:0] a, b, t, p;
        logic        dv;
        logic [4:0]  tag;
        logic [63:0] exp_res;
        logic        exp_exc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [40:0] mk_ir(input logic [6:0] op, input logic [6:0] fn);
        return {fn, 27'd0, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [40:0] ir, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] t, input logic [63:0] p, input logic dv, input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_ir    = ir;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = 64'd0;
        bus.in_t     = t;
        bus.in_p     = p;
        bus.in_div   = dv;
        bus.in_tag   = tag;
    endtask

    // Returns the edge count from the accept edge (counted as 1) to out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        drive(vecs[i].ir, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].p, vecs[i].dv, vecs[i].tag);
        check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        check($sformatf("v%0d out_res", i), bus.out_res, vecs[i].exp_res);
        check($sformatf("v%0d out_tag", i), 64'(bus.out_tag), 64'(vecs[i].tag));
        check($sformatf("v%0d out_exc", i), 64'(bus.out_exc), 64'(vecs[i].exp_exc));
        check($sformatf("v%0d in_ready at done", i), 64'(bus.in_ready), 64'd1);
        tick();
    endtask

    initial begin
        int lat;
        vecs[0] = '{mk_ir(OP_R2, FN_ADD),  64'd5,    64'd7,    64'd0,      64'd1, 1'b0, 5'd3,  64'd12,     1'b0, 2};
        vecs[1] = '{mk_ir(OP_MULI, 7'd0),  64'h10,   64'h20,   64'd0,      64'd1, 1'b0, 5'd4,  64'h200,    1'b0, 5};
        vecs[2] = '{mk_ir(OP_MULI, 7'd0),  64'h10,   64'h20,   64'd0,      64'd1, 1'b0, 5'd5,  64'h200,    1'b0, 5};
        vecs[3] = '{mk_ir(OP_DIVI, 7'd0),  64'd100,  64'd7,    64'd0,      64'd1, 1'b1, 5'd6,  64'd14,     1'b0, 3};
        vecs[4] = '{mk_ir(OP_DIVI, 7'd0),  64'd100,  64'd0,    64'd0,      64'd1, 1'b1, 5'd7,  64'd0,      1'b1, 3};
        vecs[5] = '{mk_ir(OP_R2, FN_ADD),  64'd1,    64'd2,    64'd0,      64'd1, 1'b0, 5'd8,  64'd3,      1'b0, 2};
        vecs[6] = '{mk_ir(OP_R2, FN_DIV),  64'd100,  64'd7,    64'hABCD,   64'd0, 1'b1, 5'd9,  64'hABCD,   1'b0, 2};
        vecs[7] = '{mk_ir(OP_MULUI, 7'd0), 64'd3,    64'd9,    64'd0,      64'd1, 1'b0, 5'd10, 64'd27,     1'b0, 5};
        vecs[8] = '{mk_ir(OP_R2, FN_MODU), 64'd100,  64'd7,    64'd0,      64'd1, 1'b0, 5'd11, 64'd2,      1'b0, 3};

        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.in_t      = '0;
        bus.in_p      = '0;
        bus.in_div    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_res", bus.out_res, 64'd0);
        check("reset alu_a", bus.alu_a, 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 9; i++) run_vec(i);

        // Writeback stalls three cycles, then takes the result while a new op is accepted.
        bus.out_ready = 1'b0;
        drive(mk_ir(OP_R2, FN_ADD), 64'd10, 64'd20, 64'd0, 64'd1, 1'b0, 5'd12);
        tick();
        drive(mk_ir(OP_MULI, 7'd0), 64'd2, 64'd3, 64'd0, 64'd1, 1'b0, 5'd13);
        wait_valid(lat);
        check("stall latency", 64'(lat), 64'd2);
        for (int k = 0; k < 3; k++) begin
            check("stall out_valid", 64'(bus.out_valid), 64'd1);
            check("stall out_res", bus.out_res, 64'd30);
            check("stall out_tag", 64'(bus.out_tag), 64'd12);
            check("stall in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b out_valid drop", 64'(bus.out_valid), 64'd0);
        check("b2b state", 64'(dbg_state), 64'd2);
        wait_valid(lat);
        check("b2b latency", 64'(lat), 64'd5);
        check("b2b out_res", bus.out_res, 64'd6);
        check("b2b out_tag", 64'(bus.out_tag), 64'd13);
        tick();

        // Flush while a divide waits on div_done.
        div_done_en = 1'b0;
        drive(mk_ir(OP_DIVI, 7'd0), 64'd100, 64'd7, 64'd0, 64'd1, 1'b1, 5'd14);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("dwait state", 64'(dbg_state), 64'd3);
        flush = 1'b1;
        drive(mk_ir(OP_R2, FN_ADD), 64'd55, 64'd1, 64'd0, 64'd1, 1'b0, 5'd15);
        #1;
        check("flush in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        div_done_en = 1'b1;
        check("flush state", 64'(dbg_state), 64'd0);
        check("flush alu_a held", bus.alu_a, 64'd100);
        for (int k = 0; k < 3; k++) begin
            check("flush out_valid", 64'(bus.out_valid), 64'd0);
            tick();
        end

        // Asynchronous reset in the middle of a multiply.
        drive(mk_ir(OP_MULI, 7'd0), 64'h10, 64'h20, 64'd0, 64'd1, 1'b0, 5'd16);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mwait state", 64'(dbg_state), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst state", 64'(dbg_state), 64'd0);
        check("arst alu_a", bus.alu_a, 64'd0);
        check("arst alu_ir", 64'(bus.alu_ir), 64'd0);
        check("arst out_res", bus.out_res, 64'd0);
        check("arst out_tag", 64'(bus.out_tag), 64'd0);
        check("arst out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
